// File: rtl/gray_pkg.sv
// Shared types for the Gray counter checker: FSM states, violation codes
// and the default counter width.
package gray_pkg;

    localparam int GRAY_WIDTH = 3;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_JUMP = 2'b01,
        ERR_BACK = 2'b10,
        ERR_OVF  = 2'b11
    } err_code_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above it.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    always_comb begin
        o_bin[WIDTH-1] = i_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            o_bin[i] = o_bin[i+1] ^ i_gray[i];
        end
    end

endmodule

// File: rtl/gray_checker.sv
// Tracks a Gray counter, converts it to binary, validates every transition
// and latches the first protocol violation. All outputs are registered.
module gray_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Overflow,
    output logic [WIDTH-1:0] Bin,
    output logic             Step,
    output logic             Wrap,
    output logic [CNT_W-1:0] WrapCount,
    output logic             Locked,
    output logic             Err,
    output logic [1:0]       ErrCode,
    output logic [1:0]       DbgState
);

    localparam logic [WIDTH-1:0] MAX_B = '1;

    logic [WIDTH-1:0] w_cur_b;
    logic [WIDTH-1:0] w_inc_b;
    logic [WIDTH-1:0] w_dec_b;
    logic             w_is_hold;
    logic             w_is_fwd;
    logic             w_is_wrap;
    logic             w_is_back;
    logic             w_ovf_change;
    logic             w_adv;
    err_code_t        w_code;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev_b;
    logic             r_prev_ovf;
    logic [WIDTH-1:0] r_bin;
    logic             r_step;
    logic             r_wrap;
    logic [CNT_W-1:0] r_wrap_cnt;
    logic             r_locked;
    logic             r_err;
    err_code_t        r_err_code;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .i_gray (Gray),
        .o_bin  (w_cur_b)
    );

    // Classify the transition; the if-chain order encodes JUMP > BACK > OVF.
    always_comb begin
        w_inc_b      = r_prev_b + WIDTH'(1);
        w_dec_b      = r_prev_b - WIDTH'(1);
        w_is_hold    = (w_cur_b == r_prev_b);
        w_is_fwd     = (w_cur_b == w_inc_b) && (r_prev_b != MAX_B);
        w_is_wrap    = (r_prev_b == MAX_B) && (w_cur_b == '0);
        w_is_back    = (w_cur_b == w_dec_b);
        w_ovf_change = (Overflow != r_prev_ovf);
        w_code       = ERR_NONE;
        if (w_is_hold || w_is_fwd) begin
            w_code = w_ovf_change ? ERR_OVF : ERR_NONE;
        end else if (w_is_wrap) begin
            w_code = Overflow ? ERR_NONE : ERR_OVF;
        end else if (w_is_back) begin
            w_code = ERR_BACK;
        end else begin
            w_code = ERR_JUMP;
        end
        w_adv = (w_is_fwd || w_is_wrap) && (w_code == ERR_NONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= INIT;
            r_prev_b   <= '0;
            r_prev_ovf <= 1'b0;
            r_bin      <= '0;
            r_step     <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_bin  <= w_cur_b;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                INIT: begin
                    r_prev_b   <= w_cur_b;
                    r_prev_ovf <= Overflow;
                    r_locked   <= 1'b1;
                    r_state    <= TRACK;
                end
                TRACK: begin
                    r_prev_b   <= w_cur_b;
                    r_prev_ovf <= Overflow;
                    if (w_code != ERR_NONE) begin
                        r_state    <= ERROR;
                        r_err      <= 1'b1;
                        r_err_code <= w_code;
                        r_locked   <= 1'b0;
                    end else begin
                        r_step <= w_adv;
                        r_wrap <= w_is_wrap;
                        if (w_is_wrap && (r_wrap_cnt != '1)) begin
                            r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
                        end
                    end
                end
                ERROR: begin
                    r_locked <= 1'b0;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign Bin       = r_bin;
    assign Step      = r_step;
    assign Wrap      = r_wrap;
    assign WrapCount = r_wrap_cnt;
    assign Locked    = r_locked;
    assign Err       = r_err;
    assign ErrCode   = r_err_code;
    assign DbgState  = r_state;

endmodule

// File: tb/tb_gray_checker.sv
// Directed self-checking bench for gray_checker: legal sequences, holds,
// each violation class, reset recovery and wrap-counter saturation.
module tb_gray_checker;

    logic       Clk;
    logic       Reset;
    logic [2:0] Gray;
    logic       Overflow;
    logic [2:0] Bin;
    logic       Step;
    logic       Wrap;
    logic [3:0] WrapCount;
    logic       Locked;
    logic       Err;
    logic [1:0] ErrCode;
    logic [1:0] DbgState;

    int n_checks = 0;
    int n_errors = 0;

    // Gray code of binary 0..7, written out by hand.
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    gray_checker #(.WIDTH(3), .CNT_W(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Gray      (Gray),
        .Overflow  (Overflow),
        .Bin       (Bin),
        .Step      (Step),
        .Wrap      (Wrap),
        .WrapCount (WrapCount),
        .Locked    (Locked),
        .Err       (Err),
        .ErrCode   (ErrCode),
        .DbgState  (DbgState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one sample, let the DUT register it, then settle away from the edge.
    task automatic tick(input logic [2:0] g, input logic ov);
        Gray     = g;
        Overflow = ov;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(3'b000, 1'b0);
        Reset = 1'b0;
    endtask

    // Reset, take reference 000 and advance to binary 7 with Overflow low.
    task automatic run_to_max();
        do_reset();
        tick(gseq[0], 1'b0);
        for (int b = 1; b < 8; b++) tick(gseq[b], 1'b0);
    endtask

    int         steps;
    int         wraps;
    logic [3:0] exp_cnt;

    initial begin
        Reset    = 1'b1;
        Gray     = 3'b000;
        Overflow = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("rst_bin",    8'(Bin), 8'd0);
        check_eq("rst_step",   8'(Step), 8'd0);
        check_eq("rst_wrap",   8'(Wrap), 8'd0);
        check_eq("rst_wcnt",   8'(WrapCount), 8'd0);
        check_eq("rst_locked", 8'(Locked), 8'd0);
        check_eq("rst_err",    8'(Err), 8'd0);
        check_eq("rst_code",   8'(ErrCode), 8'd0);
        check_eq("rst_state",  8'(DbgState), 8'd0);
        Reset = 1'b0;

        // 1: full legal cycle, Overflow rises with the wrap sample
        tick(3'b000, 1'b0);
        check_eq("t1_init_step", 8'(Step), 8'd0);
        check_eq("t1_locked",    8'(Locked), 8'd1);
        check_eq("t1_state",     8'(DbgState), 8'd1);
        steps = 0;
        wraps = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(gseq[i % 8], (i == 8));
            check_eq("t1_bin", 8'(Bin), 8'(i % 8));
            steps += int'(Step);
            wraps += int'(Wrap);
        end
        check_eq("t1_steps", 8'(steps), 8'd8);
        check_eq("t1_wraps", 8'(wraps), 8'd1);
        check_eq("t1_wcnt",  8'(WrapCount), 8'd1);
        check_eq("t1_err",   8'(Err), 8'd0);

        // 2: hold at 011 for five samples
        do_reset();
        tick(3'b000, 1'b0);
        tick(3'b001, 1'b0);
        tick(3'b011, 1'b0);
        check_eq("t2_step_in", 8'(Step), 8'd1);
        for (int i = 0; i < 5; i++) begin
            tick(3'b011, 1'b0);
            check_eq("t2_hold_step", 8'(Step), 8'd0);
            check_eq("t2_hold_bin",  8'(Bin), 8'd2);
            check_eq("t2_locked",    8'(Locked), 8'd1);
        end
        tick(3'b010, 1'b0);
        check_eq("t2_step_out", 8'(Step), 8'd1);
        check_eq("t2_bin_out",  8'(Bin), 8'd3);

        // 3: one wrap, then a two-bit jump 001 -> 010
        run_to_max();
        tick(3'b000, 1'b1);
        check_eq("t3_wcnt_pre", 8'(WrapCount), 8'd1);
        tick(3'b001, 1'b1);
        tick(3'b010, 1'b1);
        check_eq("t3_err",    8'(Err), 8'd1);
        check_eq("t3_code",   8'(ErrCode), 8'd1);
        check_eq("t3_bin",    8'(Bin), 8'd3);
        check_eq("t3_locked", 8'(Locked), 8'd0);
        check_eq("t3_state",  8'(DbgState), 8'd2);
        check_eq("t3_step",   8'(Step), 8'd0);
        tick(3'b110, 1'b1);
        check_eq("t3_bin_follow", 8'(Bin), 8'd4);
        tick(3'b111, 1'b1);
        check_eq("t3_bin_follow2", 8'(Bin), 8'd5);
        check_eq("t3_step_frz",    8'(Step), 8'd0);
        check_eq("t3_wcnt_frz",    8'(WrapCount), 8'd1);
        tick(3'b000, 1'b1);
        check_eq("t3_code_frz",    8'(ErrCode), 8'd1);

        // 4: backward step 011 -> 001, then Reset beats a bad sample
        do_reset();
        tick(3'b000, 1'b0);
        tick(3'b001, 1'b0);
        tick(3'b011, 1'b0);
        tick(3'b001, 1'b0);
        check_eq("t4_code", 8'(ErrCode), 8'd2);
        check_eq("t4_err",  8'(Err), 8'd1);
        Reset = 1'b1;
        tick(3'b101, 1'b1);
        Reset = 1'b0;
        check_eq("t4_rst_bin",    8'(Bin), 8'd0);
        check_eq("t4_rst_err",    8'(Err), 8'd0);
        check_eq("t4_rst_code",   8'(ErrCode), 8'd0);
        check_eq("t4_rst_locked", 8'(Locked), 8'd0);
        check_eq("t4_rst_state",  8'(DbgState), 8'd0);
        tick(3'b110, 1'b0);
        check_eq("t4_relock",  8'(Locked), 8'd1);
        check_eq("t4_ref_bin", 8'(Bin), 8'd4);
        check_eq("t4_ref_stp", 8'(Step), 8'd0);
        tick(3'b111, 1'b0);
        check_eq("t4_new_ref", 8'(Step), 8'd1);

        // 4b: backward across the boundary 000 -> 100 (0 -> 7)
        do_reset();
        tick(3'b000, 1'b0);
        tick(3'b100, 1'b0);
        check_eq("t4b_code", 8'(ErrCode), 8'd2);

        // 5a: wrap with Overflow still low
        run_to_max();
        tick(3'b000, 1'b0);
        check_eq("t5a_code", 8'(ErrCode), 8'd3);
        check_eq("t5a_wrap", 8'(Wrap), 8'd0);
        check_eq("t5a_wcnt", 8'(WrapCount), 8'd0);

        // 5b: Overflow rising on an ordinary step 010 -> 110
        do_reset();
        tick(3'b000, 1'b0);
        tick(3'b001, 1'b0);
        tick(3'b011, 1'b0);
        tick(3'b010, 1'b0);
        tick(3'b110, 1'b1);
        check_eq("t5b_code", 8'(ErrCode), 8'd3);
        check_eq("t5b_step", 8'(Step), 8'd0);

        // 5c: Overflow falling during a hold
        run_to_max();
        tick(3'b000, 1'b1);
        tick(3'b000, 1'b0);
        check_eq("t5c_code", 8'(ErrCode), 8'd3);

        // 5d: jump together with an Overflow change reports the jump
        do_reset();
        tick(3'b000, 1'b0);
        tick(3'b011, 1'b1);
        check_eq("t5d_code", 8'(ErrCode), 8'd1);

        // 6: twenty legal wraps, counter saturates at 15
        do_reset();
        tick(3'b000, 1'b0);
        for (int w = 1; w <= 20; w++) begin
            for (int b = 1; b < 8; b++) tick(gseq[b], (w > 1));
            tick(3'b000, 1'b1);
            exp_cnt = (w > 15) ? 4'd15 : 4'(w);
            check_eq("t6_step", 8'(Step), 8'd1);
            check_eq("t6_wrap", 8'(Wrap), 8'd1);
            check_eq("t6_wcnt", 8'(WrapCount), 8'(exp_cnt));
        end
        check_eq("t6_err", 8'(Err), 8'd0);
        tick(3'b000, 1'b1);
        check_eq("t6_wrap_pulse", 8'(Wrap), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_checker.md
# gray_checker

Downstream consumer of the 3-bit `gray` counter.

- Samples the counter's `Output` and `Overflow` every cycle and converts the Gray code to binary.
- Validates every transition against the counter's contract: hold, +1 step, or wrap with overflow.
- Counts wrap events and latches the first protocol violation with a diagnostic code.
- Sits between the counter and the display/LED logic, which read `Bin`, `Step`, `WrapCount` and `Err` from it.

## Interface

Parameters:
- `WIDTH`, 3, width of the Gray input and binary output.
- `CNT_W`, 4, width of the saturating wrap counter.

Ports:
- `Clk` input 1: the single clock; everything is rising-edge.
- `Reset` input 1: synchronous, active-high; clears all state on the next rising edge of `Clk`.
- `Gray` input `WIDTH`: counter value, driven from `gray.Output`.
- `Overflow` input 1: counter overflow flag, driven from `gray.Overflow`. It is sticky in the source: once high, it stays high until `Reset`.
- `Bin` output `WIDTH`: registered binary equivalent of the last sampled `Gray`.
- `Step` output 1: one-cycle pulse on each legal +1 advance, including the wrap.
- `Wrap` output 1: one-cycle pulse on the legal max→0 advance.
- `WrapCount` output `CNT_W`: number of wraps seen; saturates at 2^`CNT_W`−1.
- `Locked` output 1: high while in `TRACK`.
- `Err` output 1: sticky violation flag.
- `ErrCode` output 2: cause of the first violation; frozen once `Err` is set.

## Operation

Gray→binary conversion:
- `b[W-1] = g[W-1]`
- `b[i] = b[i+1] ^ g[i]`
- Arithmetic is mod 2^`WIDTH`.

Internal state: the previous sample `prev_b`, the previous overflow `prev_ovf`, and the FSM.

FSM:
- `INIT` (reset state):
  - Captures `Gray` and `Overflow` as the reference, then goes to `TRACK`.
  - No `Step` is generated in this cycle.
- `TRACK`: compares the current binary value `cur_b` against `prev_b` each cycle.
  - `cur_b == prev_b`: hold. If `Overflow` rises (0→1) during a hold, go to `ERROR` with code 11.
  - `cur_b == prev_b+1` and `prev_b != max`: legal step; pulse `Step`. If `Overflow` rises here, go to `ERROR` with code 11.
  - `prev_b == max` and `cur_b == 0`: legal wrap; pulse `Step` and `Wrap`, and increment `WrapCount` (saturating).
    - `Overflow` must read 1 in this same sample. If it reads 0, go to `ERROR` with code 11.
    - A wrap while `Overflow` is already high is legal.
  - `cur_b == prev_b-1`: backward step; go to `ERROR` with code 10.
  - Any other change (Hamming distance of `Gray` > 1, or a skip): go to `ERROR` with code 01.
  - `Overflow` falling 1→0 without `Reset` is also a violation: code 11.
- `ERROR`:
  - `Err = 1`, `Locked = 0`, `ErrCode` frozen.
  - `Bin` keeps following the input.
  - `Step`, `Wrap` and `WrapCount` are frozen.
  - Exit only via `Reset`.

Error-code priority when several causes apply in one sample: 01 > 10 > 11.

Reset values:
- `Bin` = 0, `Step` = 0, `Wrap` = 0, `WrapCount` = 0, `Locked` = 0, `Err` = 0, `ErrCode` = 00.
- State = `INIT`.
- `Reset` mid-operation (any state) behaves identically and discards `prev_b`.

## Timing

- All outputs are registered. The response to a sample taken at edge N is visible after edge N+1 (one-cycle latency).
- `Step` and `Wrap` are high for exactly one cycle per event.
- Back-to-back steps on consecutive cycles produce consecutive `Step` pulses.
- `Locked` rises one cycle after the first post-reset edge, i.e. when `INIT` → `TRACK`.
- `Err` and `ErrCode` update on the same edge as the FSM enters `ERROR`.
- `Reset` has priority over every other event in the same cycle.
- No combinational path from inputs to outputs.

## Structure

Shared package `gray_pkg`:
- State encoding `INIT` / `TRACK` / `ERROR`.
- Error codes `ERR_NONE` = 00, `ERR_JUMP` = 01, `ERR_BACK` = 10, `ERR_OVF` = 11.
- Default `WIDTH`.

Sub-module `gray2bin`: a parameterised combinational converter. It is instantiated once for `Gray`. `prev_b` is stored already in binary, so no second converter is needed.

## Test plan

1. Reset, then drive the full sequence 000,001,011,010,110,111,101,100,000 with `Overflow` rising on the last sample:
   - `Bin` follows 0..7,0.
   - 8 `Step` pulses, 1 `Wrap` pulse.
   - `WrapCount` = 1, `Err` = 0.
2. Hold `Gray` = 011 for 5 cycles between steps:
   - No `Step` during the hold.
   - `Bin` stays at 2.
   - `Locked` = 1 throughout.
3. Jump 001→010 (two bits change):
   - `Err` = 1, `ErrCode` = 01.
   - `Bin` = 3 and continues to follow the input.
   - `WrapCount` frozen.
4. Step 011→001 (backward):
   - `ErrCode` = 10.
   - Then assert `Reset` for one cycle: all outputs return to 0 and the FSM goes to `INIT` → `TRACK`.
5. Wrap 100→000 with `Overflow` = 0 gives `ErrCode` = 11. In a separate run, `Overflow` rising at 010→110 also gives `ErrCode` = 11.
6. 20 legal wraps with `CNT_W` = 4:
   - `WrapCount` saturates at 15.
   - `Step` and `Wrap` keep pulsing.
   - `Err` = 0.
